// File: rtl/permute_unit_if.sv
// permute_unit_if
//   Operand/result handshake bundle for the permutation unit.
//   Parameters:
//     WIDTH  operand/result width in bits (multiple of 8, >= 8)
//     TAG_W  width of the opaque tag travelling with each beat
//   Signals:
//     in_valid/in_ready/in_data/in_mode/in_tag      operand beat (producer -> unit)
//     out_valid/out_ready/out_data/out_tag          result beat (unit -> consumer)
//   Modports:
//     master  producer/consumer side (drives operands, accepts results)
//     slave   the permutation unit itself
interface permute_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/permute_unit.sv
// permute_unit
//   Two-stage bit/byte permutation unit. S1 captures the operand, the
//   permutation is computed combinationally from S1 and registered into S2,
//   which drives the result handshake.
//   Modes: 00 pass, 01 full bit reverse, 10 byte reverse, 11 bit reverse
//   within each byte.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    permute_unit_if.slave (operand in / result out handshake)
//     busy   high while either stage holds a beat
//   WIDTH must be a multiple of 8 and at least 8; TAG_W at least 1.
module permute_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    permute_unit_if.slave        bus,
    output logic                 busy
);
    localparam int NB = WIDTH / 8;

    // Stage 1: capture register
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2: result register
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic s2_adv;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    logic [NB-1:0][7:0] s1_bytes;
    logic [NB-1:0][7:0] perm_bytes;

    function automatic logic [7:0] brev8(input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j] = b[7-j];
        end
        return r;
    endfunction

    assign s1_bytes = s1_data_q;

    // Every mode reduces to a per-byte choice between the lane's own byte and
    // its mirror byte, optionally bit-reversed: a full bit reverse is a byte
    // reverse with each byte also reversed internally.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [7:0] own_byte;
        logic [7:0] mirror_byte;
        logic [7:0] lane_res;

        assign own_byte    = s1_bytes[k];
        assign mirror_byte = s1_bytes[NB-1-k];

        always_comb begin
            lane_res = own_byte;
            case (s1_mode_q)
                2'b00:   lane_res = own_byte;
                2'b01:   lane_res = brev8(mirror_byte);
                2'b10:   lane_res = mirror_byte;
                default: lane_res = brev8(own_byte);
            endcase
        end

        assign perm_bytes[k] = lane_res;
    end

    // Handshake. in_ready looks through to out_ready so a full pipe reopens in
    // the same cycle the consumer accepts; held low during reset.
    always_comb begin
        s2_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready = rst_n && (!s1_valid_q || s2_adv);
        in_fire  = bus.in_valid && in_ready;
        out_fire = s2_valid_q && bus.out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.in_data;
            s1_mode_d  = bus.in_mode;
            s1_tag_d   = bus.in_tag;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 only changes on s2_adv or out_fire, so the result is held steady
    // while the consumer stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = perm_bytes;
            s2_tag_d   = s1_tag_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    // S1 payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        s1_mode_q <= s1_mode_d;
        s1_tag_q  <= s1_tag_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_tag   = s2_tag_q;
    assign busy          = s1_valid_q || s2_valid_q;
endmodule
